// File: rtl/fp_axis_packetizer.sv
// Packs sign/exponent/fraction results into 64-bit AXI-stream beats framed into PKT_LEN packets.
// Latency: accept at edge k, earliest move to output at k+1; backpressure via in_ready when hold and output are both full.
module fp_axis_packetizer #(
    parameter int EXPO_W  = 11,
    parameter int FRAC_W  = 52,
    parameter int PKT_LEN = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk25mhz_0,
    input  logic              peripheral_reset_0,
    input  logic              in_sign,
    input  logic [EXPO_W-1:0] in_expo,
    input  logic [FRAC_W-1:0] in_frac,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [63:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [7:0]        m_axis_tkeep,
    output logic [15:0]       pkt_count
);

    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] LAST_V = BW'(PKT_LEN - 1);
    localparam logic [IW-1:0] TMO_V  = IW'(TIMEOUT);

    logic [63:0]   h_dat_q, h_dat_d;
    logic          h_vld_q, h_vld_d;
    logic [63:0]   o_dat_q, o_dat_d;
    logic          o_last_q, o_last_d;
    logic          o_vld_q, o_vld_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          flush_pend_q, flush_pend_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;

    logic [63:0] in_dat;
    logic        slot_free, acc, at_end, tmo, fl, move, mv_last;

    assign in_dat    = {in_sign, in_expo, in_frac};
    assign slot_free = !o_vld_q || m_axis_tready;
    assign in_ready  = !h_vld_q || slot_free;
    assign acc       = in_valid && in_ready;
    assign at_end    = (beat_cnt_q == LAST_V);
    assign tmo       = (TIMEOUT != 0) && (idle_cnt_q == TMO_V);
    assign fl        = flush_pend_q || flush;
    assign move      = h_vld_q && slot_free && (acc || at_end || tmo || fl);
    // Any close reason forces tlast; a plain acc-driven move closes only at the packet boundary.
    assign mv_last   = at_end || tmo || fl;

    always_comb begin
        h_dat_d      = h_dat_q;
        h_vld_d      = h_vld_q;
        o_dat_d      = o_dat_q;
        o_last_d     = o_last_q;
        o_vld_d      = o_vld_q;
        beat_cnt_d   = beat_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        flush_pend_d = flush_pend_q;
        pkt_cnt_d    = pkt_cnt_q;

        if (move) begin
            o_dat_d      = h_dat_q;
            o_last_d     = mv_last;
            o_vld_d      = 1'b1;
            beat_cnt_d   = mv_last ? '0 : beat_cnt_q + BW'(1);
            flush_pend_d = 1'b0;
            h_vld_d      = 1'b0;
        end else begin
            if (o_vld_q && m_axis_tready) begin
                o_vld_d = 1'b0;
            end
            if (flush && h_vld_q) begin
                flush_pend_d = 1'b1;
            end
        end

        if (acc) begin
            h_dat_d = in_dat;
            h_vld_d = 1'b1;
        end

        if (acc || !h_vld_q) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != TMO_V) begin
            idle_cnt_d = idle_cnt_q + IW'(1);
        end

        if (o_vld_q && m_axis_tready && o_last_q) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk25mhz_0) begin
        if (peripheral_reset_0) begin
            h_dat_q      <= '0;
            h_vld_q      <= 1'b0;
            o_dat_q      <= '0;
            o_last_q     <= 1'b0;
            o_vld_q      <= 1'b0;
            beat_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            h_dat_q      <= h_dat_d;
            h_vld_q      <= h_vld_d;
            o_dat_q      <= o_dat_d;
            o_last_q     <= o_last_d;
            o_vld_q      <= o_vld_d;
            beat_cnt_q   <= beat_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            flush_pend_q <= flush_pend_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign m_axis_tdata  = o_dat_q;
    assign m_axis_tvalid = o_vld_q;
    assign m_axis_tlast  = o_last_q;
    assign m_axis_tkeep  = 8'hFF;
    assign pkt_count     = pkt_cnt_q;

endmodule
